hdr_frame_tracker: RTL and testbench
====================================

Name: hdr_frame_tracker

Overview:
Parametrised successor to the HDR target frame counter. Tracks the remaining HDR-DDR data frames of a transfer. Sources the limit from the write-length, read-length or CCC-length register. Signals almost-last, last and overrun to the target FSM. Adds a byte-length mode, hold, abort, a remaining-count readout and saturation in place of wrap-around.

Parameters:
CNT_W, 16, width of length registers and remaining counter
BITCNT_W, 6, width of bit-counter input
TICK_A, 6, bit count that marks a frame boundary (short/command frame)
TICK_B, 16, bit count that marks a frame boundary (data frame)
BYTE_MODE, 0, 1 = length registers hold bytes, frames = ceil(len/2); 0 = length registers hold frames

Ports:
i_fcnt_clk  in  1  clock
i_fcnt_rst_n  in  1  asynchronous active-low reset
i_fcnt_en  in  1  enables tracking; low = idle/reload
i_fcnt_hold  in  1  freezes counter and state (ticks ignored)
i_fcnt_abort  in  1  synchronous abort to IDLE
i_nt_rnw  in  1  1 = read transfer, 0 = write
i_fcnt_ccc  in  1  1 = CCC transfer (overrides rnw)
i_regf_MAX_RD_LEN  in  CNT_W  read length
i_regf_MAX_WR_LEN  in  CNT_W  write length
i_regf_CCC_LEN  in  CNT_W  CCC payload length
i_cnt_bit_count  in  BITCNT_W  current bit position
i_bitcnt_toggle  in  1  bit-counter advance strobe
o_fcnt_remaining  out  CNT_W  frames remaining
o_fcnt_almost_last  out  1  remaining == 1 in COUNT
o_fcnt_last_frame  out  1  level, high in LAST
o_fcnt_last_pulse  out  1  one-cycle pulse on entry to LAST
o_fcnt_overrun  out  1  sticky: a tick arrived while in LAST

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; remaining 0.
- Tick definition: tick = i_bitcnt_toggle && (bit_count==TICK_A || bit_count==TICK_B). No other condition produces a tick.
- Load value L is selected with priority ccc > rnw: CCC_LEN, else RD_LEN if rnw, else WR_LEN.
- BYTE_MODE=1: L = (len+1)>>1, computed in CNT_W+1 bits. Example: 0xFFFF -> 0x8000; 0 -> 0; 1 -> 1.
- IDLE: remaining <= L every cycle. Overrun, last and almost_last are held at 0.
  - en=1 and L==0 -> LAST, with last_pulse.
  - en=1 and L!=0 -> COUNT.
- COUNT: on each tick, remaining <= remaining-1.
  - The edge on which remaining goes 1 -> 0 also enters LAST. last_frame and last_pulse are high in the following cycle. Latency is one clock from the final tick.
  - almost_last = (remaining==1) while in COUNT, registered alongside remaining.
- LAST: remaining stays 0 and saturates, never wrapping to all-ones. A tick sets overrun, which is sticky until IDLE.
- last_pulse is high exactly one cycle per transfer.
- hold=1 (COUNT/LAST): state, remaining and flags are frozen; ticks are dropped. hold in IDLE has no effect.
- Priority on a single edge: abort > en low > hold > tick.
  - abort or en=0 in any state -> IDLE next edge, outputs cleared.
- Simultaneous abort and tick: the tick is ignored.
- Length-register changes during COUNT/LAST are ignored; the value is sampled only in IDLE.
- Reset mid-transfer: immediate return to reset values.
- Re-enable after LAST requires en low for at least one cycle to pass through IDLE.

Decomposition:
- Shared HDR target package: state enum (IDLE, COUNT, LAST), default TICK_A/TICK_B constants, and function byte_to_frames(len, CNT_W).
- One natural sub-module: hdr_frame_tick_detect, holding the tick comparator and strobe qualification, parametrised on BITCNT_W/TICK_A/TICK_B. It is reused by the controller-side counter.

Test Plan:
- Write, WR_LEN=3, en=1, ticks at bit_count 16 -> remaining 3,2,1,0. almost_last high while remaining=1. last_frame high one clock after third tick. last_pulse single cycle.
- Read with ccc=1, CCC_LEN=0, RD_LEN=5 -> LAST on first edge after en. Overrun stays 0 until a tick arrives, then 1 and sticky. remaining=0.
- BYTE_MODE=1, RD_LEN=0xFFFF, rnw=1 -> remaining loads 0x8000. RD_LEN=5 -> 3 frames before last_frame.
- Toggle at bit_count 7 and bit_count 6 without toggle -> no decrement. Toggle at 6 -> decrement.
- WR_LEN=4, hold=1 across two ticks after first decrement -> remaining stays 3. Release hold, then 3 ticks -> LAST.
- Abort coinciding with the final tick -> IDLE, last_frame/last_pulse never assert. Async reset mid-COUNT -> all outputs 0 immediately.

Source files
------------

// File: rtl/hdr_frame_tracker_pkg.sv
// -----------------------------------------------------------------------------
// hdr_frame_tracker_pkg
// Shared definitions for the HDR target frame tracking logic:
//   - fcnt_state_e   : tracker state encoding (IDLE, COUNT, LAST)
//   - DEF_TICK_A/B   : default bit positions that mark a frame boundary
//   - byte_to_frames : converts a byte length into a DDR frame count
//                      (two bytes per frame, rounded up)
// -----------------------------------------------------------------------------
package hdr_frame_tracker_pkg;

  typedef enum logic [1:0] {
    FCNT_IDLE  = 2'd0,
    FCNT_COUNT = 2'd1,
    FCNT_LAST  = 2'd2
  } fcnt_state_e;

  // Bit position of the short/command frame boundary.
  localparam int DEF_TICK_A = 6;
  // Bit position of the data frame boundary.
  localparam int DEF_TICK_B = 16;

  // Widest length register the conversion helper supports.
  localparam int MAX_CNT_W = 32;

  // frames = ceil(len / 2) = (len + 1) >> 1.
  // The length is first masked to cnt_w bits and the sum is carried one bit
  // wider than the register, so an all-ones length gives 2^(cnt_w-1) instead
  // of wrapping to zero. The caller truncates the result back to cnt_w bits.
  function automatic logic [31:0] byte_to_frames(input logic [31:0] len,
                                                 input int          cnt_w);
    logic [32:0] mask;
    logic [32:0] sum;
    mask = (33'd1 << cnt_w) - 33'd1;
    sum  = ({1'b0, len} & mask) + 33'd1;
    return sum[32:1];
  endfunction

endpackage

// File: rtl/hdr_frame_tick_detect.sv
// -----------------------------------------------------------------------------
// hdr_frame_tick_detect
// Frame boundary detector. A tick is produced only when the bit-counter
// advance strobe is high while the bit counter sits on one of the two frame
// boundary positions. Purely combinational so the consumer sees the tick in
// the same cycle as the strobe. Shared by target- and controller-side counters.
//
// Ports:
//   bit_count  in  BITCNT_W  current bit position of the bit counter
//   toggle     in  1         bit-counter advance strobe
//   tick       out 1         frame boundary reached this cycle
// -----------------------------------------------------------------------------
module hdr_frame_tick_detect
  import hdr_frame_tracker_pkg::*;
#(
  parameter int BITCNT_W = 6,
  parameter int TICK_A   = DEF_TICK_A,
  parameter int TICK_B   = DEF_TICK_B
) (
  input  logic [BITCNT_W-1:0] bit_count,
  input  logic                toggle,
  output logic                tick
);

  localparam logic [BITCNT_W-1:0] POS_A = BITCNT_W'(TICK_A);
  localparam logic [BITCNT_W-1:0] POS_B = BITCNT_W'(TICK_B);

  logic hit_a;
  logic hit_b;

  assign hit_a = (bit_count == POS_A);
  assign hit_b = (bit_count == POS_B);

  // The strobe qualifies the compare: a counter parked on a boundary position
  // without advancing must not count a second frame.
  assign tick = toggle & (hit_a | hit_b);

endmodule

// File: rtl/hdr_frame_tracker.sv
// -----------------------------------------------------------------------------
// hdr_frame_tracker
// Tracks the remaining HDR-DDR data frames of a transfer for the target FSM.
// The frame limit is sampled from the CCC, read or write length register while
// idle; every frame boundary tick then counts it down. The counter saturates
// at zero in LAST, where a further tick raises a sticky overrun flag.
//
// Ports:
//   i_fcnt_clk          in  1         clock
//   i_fcnt_rst_n        in  1         asynchronous active-low reset
//   i_fcnt_en           in  1         tracking enable; low returns to IDLE/reload
//   i_fcnt_hold         in  1         freeze counter and state (ticks dropped)
//   i_fcnt_abort        in  1         synchronous abort to IDLE
//   i_nt_rnw            in  1         1 = read transfer, 0 = write
//   i_fcnt_ccc          in  1         1 = CCC transfer (overrides rnw)
//   i_regf_MAX_RD_LEN   in  CNT_W     read length
//   i_regf_MAX_WR_LEN   in  CNT_W     write length
//   i_regf_CCC_LEN      in  CNT_W     CCC payload length
//   i_cnt_bit_count     in  BITCNT_W  current bit position
//   i_bitcnt_toggle     in  1         bit-counter advance strobe
//   o_fcnt_remaining    out CNT_W     frames remaining
//   o_fcnt_almost_last  out 1         remaining == 1 while counting
//   o_fcnt_last_frame   out 1         level, high while in LAST
//   o_fcnt_last_pulse   out 1         one-cycle pulse on entry to LAST
//   o_fcnt_overrun      out 1         sticky: tick seen while in LAST
// -----------------------------------------------------------------------------
module hdr_frame_tracker
  import hdr_frame_tracker_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int BITCNT_W  = 6,
  parameter int TICK_A    = DEF_TICK_A,
  parameter int TICK_B    = DEF_TICK_B,
  parameter int BYTE_MODE = 0
) (
  input  logic                i_fcnt_clk,
  input  logic                i_fcnt_rst_n,
  input  logic                i_fcnt_en,
  input  logic                i_fcnt_hold,
  input  logic                i_fcnt_abort,
  input  logic                i_nt_rnw,
  input  logic                i_fcnt_ccc,
  input  logic [CNT_W-1:0]    i_regf_MAX_RD_LEN,
  input  logic [CNT_W-1:0]    i_regf_MAX_WR_LEN,
  input  logic [CNT_W-1:0]    i_regf_CCC_LEN,
  input  logic [BITCNT_W-1:0] i_cnt_bit_count,
  input  logic                i_bitcnt_toggle,
  output logic [CNT_W-1:0]    o_fcnt_remaining,
  output logic                o_fcnt_almost_last,
  output logic                o_fcnt_last_frame,
  output logic                o_fcnt_last_pulse,
  output logic                o_fcnt_overrun
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  // ---------------------------------------------------------------------------
  // Frame boundary detection
  // ---------------------------------------------------------------------------
  logic tick;

  hdr_frame_tick_detect #(
    .BITCNT_W (BITCNT_W),
    .TICK_A   (TICK_A),
    .TICK_B   (TICK_B)
  ) u_tick_detect (
    .bit_count (i_cnt_bit_count),
    .toggle    (i_bitcnt_toggle),
    .tick      (tick)
  );

  // ---------------------------------------------------------------------------
  // Load value selection: CCC length wins over the read/write choice.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] len_sel;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    len_sel = i_regf_MAX_WR_LEN;
    if (i_fcnt_ccc) begin
      len_sel = i_regf_CCC_LEN;
    end else if (i_nt_rnw) begin
      len_sel = i_regf_MAX_RD_LEN;
    end
  end

  generate
    if (BYTE_MODE != 0) begin : g_byte_len
      assign load_val = CNT_W'(byte_to_frames(32'(len_sel), CNT_W));
    end else begin : g_frame_len
      assign load_val = len_sel;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  fcnt_state_e      state_reg,     state_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             almost_reg,    almost_next;
  logic             last_reg,      last_next;
  logic             pulse_reg,     pulse_next;
  logic             overrun_reg,   overrun_next;

  always_ff @(posedge i_fcnt_clk or negedge i_fcnt_rst_n) begin
    if (!i_fcnt_rst_n) begin
      state_reg     <= FCNT_IDLE;
      remaining_reg <= '0;
      almost_reg    <= 1'b0;
      last_reg      <= 1'b0;
      pulse_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      almost_reg    <= almost_next;
      last_reg      <= last_next;
      pulse_reg     <= pulse_next;
      overrun_reg   <= overrun_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Edge priority: abort > en low > hold > tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    almost_next    = almost_reg;
    last_next      = last_reg;
    overrun_next   = overrun_reg;
    // The pulse is never frozen by hold, so it stays exactly one cycle wide
    // even if hold is raised right after entry to LAST.
    pulse_next     = 1'b0;

    if (i_fcnt_abort) begin
      // Abort wins over everything, including a tick on the same edge.
      state_next     = FCNT_IDLE;
      remaining_next = '0;
      almost_next    = 1'b0;
      last_next      = 1'b0;
      overrun_next   = 1'b0;
    end else begin
      unique case (state_reg)
        FCNT_IDLE: begin
          // Continuous reload: the length register is only sampled here, so
          // later changes during COUNT/LAST have no effect on this transfer.
          remaining_next = load_val;
          almost_next    = 1'b0;
          last_next      = 1'b0;
          overrun_next   = 1'b0;
          if (i_fcnt_en) begin
            if (load_val == '0) begin
              state_next = FCNT_LAST;
              last_next  = 1'b1;
              pulse_next = 1'b1;
            end else begin
              state_next  = FCNT_COUNT;
              almost_next = (load_val == ONE);
            end
          end
        end

        FCNT_COUNT, FCNT_LAST: begin
          if (!i_fcnt_en) begin
            state_next     = FCNT_IDLE;
            remaining_next = '0;
            almost_next    = 1'b0;
            last_next      = 1'b0;
            overrun_next   = 1'b0;
          end else if (i_fcnt_hold) begin
            // Frozen: keep state, count and sticky flags; drop the tick.
          end else if (tick) begin
            if (state_reg == FCNT_LAST) begin
              // Counter saturates at zero; the extra frame is reported.
              overrun_next = 1'b1;
            end else if (remaining_reg <= ONE) begin
              // Final frame consumed: LAST is visible one clock after the tick.
              state_next     = FCNT_LAST;
              remaining_next = '0;
              almost_next    = 1'b0;
              last_next      = 1'b1;
              pulse_next     = 1'b1;
            end else begin
              remaining_next = remaining_reg - ONE;
              almost_next    = (remaining_reg == TWO);
            end
          end
        end

        default: begin
          // Unused encoding: recover to a clean IDLE.
          state_next     = FCNT_IDLE;
          remaining_next = '0;
          almost_next    = 1'b0;
          last_next      = 1'b0;
          overrun_next   = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers.
  // ---------------------------------------------------------------------------
  assign o_fcnt_remaining   = remaining_reg;
  assign o_fcnt_almost_last = almost_reg;
  assign o_fcnt_last_frame  = last_reg;
  assign o_fcnt_last_pulse  = pulse_reg;
  assign o_fcnt_overrun     = overrun_reg;

endmodule

// File: tb/tb_hdr_frame_tracker.sv
// -----------------------------------------------------------------------------
// tb_hdr_frame_tracker
// Self-checking bench for hdr_frame_tracker. Two instances share all inputs:
// dut0 counts frames directly, dut1 runs in byte-length mode. Each scenario
// task drives a table of stimulus rows; the expected outputs of each row are
// pushed to a queue as the row is driven and popped once the clock edge has
// produced the DUT response.
// -----------------------------------------------------------------------------
module tb_hdr_frame_tracker;

  typedef struct packed {
    logic [15:0] rem;
    logic        al;
    logic        lf;
    logic        lp;
    logic        ov;
  } obs_t;

  typedef struct packed {
    logic       en;
    logic       hold;
    logic       abort;
    logic       tog;
    logic [5:0] bc;
    obs_t       exp;
  } row_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        hold;
  logic        abort;
  logic        rnw;
  logic        ccc;
  logic [15:0] rd_len;
  logic [15:0] wr_len;
  logic [15:0] ccc_len;
  logic [5:0]  bc;
  logic        tog;

  logic [15:0] rem0, rem1;
  logic        al0, lf0, lp0, ov0;
  logic        al1, lf1, lp1, ov1;

  obs_t got0, got1;
  assign got0 = {rem0, al0, lf0, lp0, ov0};
  assign got1 = {rem1, al1, lf1, lp1, ov1};

  obs_t exp_q[$];
  int   total;
  int   bad;

  hdr_frame_tracker #(.CNT_W(16), .BITCNT_W(6), .TICK_A(6), .TICK_B(16), .BYTE_MODE(0)) dut0 (
    .i_fcnt_clk         (clk),
    .i_fcnt_rst_n       (rst_n),
    .i_fcnt_en          (en),
    .i_fcnt_hold        (hold),
    .i_fcnt_abort       (abort),
    .i_nt_rnw           (rnw),
    .i_fcnt_ccc         (ccc),
    .i_regf_MAX_RD_LEN  (rd_len),
    .i_regf_MAX_WR_LEN  (wr_len),
    .i_regf_CCC_LEN     (ccc_len),
    .i_cnt_bit_count    (bc),
    .i_bitcnt_toggle    (tog),
    .o_fcnt_remaining   (rem0),
    .o_fcnt_almost_last (al0),
    .o_fcnt_last_frame  (lf0),
    .o_fcnt_last_pulse  (lp0),
    .o_fcnt_overrun     (ov0)
  );

  hdr_frame_tracker #(.CNT_W(16), .BITCNT_W(6), .TICK_A(6), .TICK_B(16), .BYTE_MODE(1)) dut1 (
    .i_fcnt_clk         (clk),
    .i_fcnt_rst_n       (rst_n),
    .i_fcnt_en          (en),
    .i_fcnt_hold        (hold),
    .i_fcnt_abort       (abort),
    .i_nt_rnw           (rnw),
    .i_fcnt_ccc         (ccc),
    .i_regf_MAX_RD_LEN  (rd_len),
    .i_regf_MAX_WR_LEN  (wr_len),
    .i_regf_CCC_LEN     (ccc_len),
    .i_cnt_bit_count    (bc),
    .i_bitcnt_toggle    (tog),
    .o_fcnt_remaining   (rem1),
    .o_fcnt_almost_last (al1),
    .o_fcnt_last_frame  (lf1),
    .o_fcnt_last_pulse  (lp1),
    .o_fcnt_overrun     (ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // Build one stimulus row: inputs en/hold/abort/toggle/bit_count followed by
  // the expected remaining/almost_last/last_frame/last_pulse/overrun.
  function automatic row_t mk(input int e, input int h, input int a, input int t, input int b,
                              input int rm, input int al, input int lf, input int lp, input int ov);
    row_t r;
    r.en      = 1'(e);
    r.hold    = 1'(h);
    r.abort   = 1'(a);
    r.tog     = 1'(t);
    r.bc      = 6'(b);
    r.exp.rem = 16'(rm);
    r.exp.al  = 1'(al);
    r.exp.lf  = 1'(lf);
    r.exp.lp  = 1'(lp);
    r.exp.ov  = 1'(ov);
    return r;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("rem=%h al=%b lf=%b lp=%b ov=%b", o.rem, o.al, o.lf, o.lp, o.ov);
  endfunction

  // Drive one row, queue its expectation and let one clock edge pass.
  task automatic apply(input row_t r);
    en    = r.en;
    hold  = r.hold;
    abort = r.abort;
    tog   = r.tog;
    bc    = r.bc;
    exp_q.push_back(r.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    en = 1'b0; hold = 1'b0; abort = 1'b0; tog = 1'b0; bc = '0;
    rnw = 1'b0; ccc = 1'b0; rd_len = 16'd0; wr_len = 16'd3; ccc_len = 16'd0;
    exp_q.push_back('0);
    exp_q.push_back('0);
    repeat (3) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (got0 !== e) begin
      bad++;
      $display("FAIL reset_dut0: got %s want %s", fmt(got0), fmt(e));
    end else $display("ok   reset_dut0: %s", fmt(got0));
    e = exp_q.pop_front();
    total++;
    if (got1 !== e) begin
      bad++;
      $display("FAIL reset_dut1: got %s want %s", fmt(got1), fmt(e));
    end else $display("ok   reset_dut1: %s", fmt(got1));
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    row_t rows[$];
    obs_t e;
    rnw = 1'b0; ccc = 1'b0; wr_len = 16'd3;
    rows.push_back(mk(0,0,0,0,0,  3,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,  3,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 2,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 1,1,0,0,0));
    rows.push_back(mk(1,0,0,0,16, 1,1,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 0,0,1,1,0));
    rows.push_back(mk(1,0,0,0,0,  0,0,1,0,0));
    rows.push_back(mk(1,0,0,0,0,  0,0,1,0,0));
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  3,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if (got0 !== e) begin
        bad++;
        $display("FAIL write[%0d]: got %s want %s", i, fmt(got0), fmt(e));
      end else $display("ok   write[%0d]: %s", i, fmt(got0));
    end
  endtask

  task automatic test_ccc_zero();
    row_t rows[$];
    obs_t e;
    rnw = 1'b1; ccc = 1'b1; ccc_len = 16'd0; rd_len = 16'd5;
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,  0,0,1,1,0));
    rows.push_back(mk(1,0,0,0,0,  0,0,1,0,0));
    rows.push_back(mk(1,0,0,1,6,  0,0,1,0,1));
    rows.push_back(mk(1,0,0,0,0,  0,0,1,0,1));
    rows.push_back(mk(1,0,0,1,16, 0,0,1,0,1));
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if (got0 !== e) begin
        bad++;
        $display("FAIL ccc_zero[%0d]: got %s want %s", i, fmt(got0), fmt(e));
      end else $display("ok   ccc_zero[%0d]: %s", i, fmt(got0));
    end
  endtask

  task automatic test_byte_mode();
    row_t rows[$];
    obs_t e;
    rnw = 1'b1; ccc = 1'b0;
    rows.push_back(mk(0,0,0,0,0,  16'h8000,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  1,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  3,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,  3,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 2,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 1,1,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 0,0,1,1,0));
    rows.push_back(mk(1,0,0,0,0,  0,0,1,0,0));
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      if (i == 0) rd_len = 16'hFFFF;
      if (i == 1) rd_len = 16'd1;
      if (i == 2) rd_len = 16'd0;
      if (i == 3) rd_len = 16'd5;
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if (got1 !== e) begin
        bad++;
        $display("FAIL byte_mode[%0d]: got %s want %s", i, fmt(got1), fmt(e));
      end else $display("ok   byte_mode[%0d]: %s", i, fmt(got1));
    end
  endtask

  task automatic test_tick_qual();
    row_t rows[$];
    obs_t e;
    rnw = 1'b0; ccc = 1'b0; wr_len = 16'd4;
    rows.push_back(mk(0,0,0,0,0,  4,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,  4,0,0,0,0));
    rows.push_back(mk(1,0,0,1,7,  4,0,0,0,0));
    rows.push_back(mk(1,0,0,0,6,  4,0,0,0,0));
    rows.push_back(mk(1,0,0,0,16, 4,0,0,0,0));
    rows.push_back(mk(1,0,0,1,0,  4,0,0,0,0));
    rows.push_back(mk(1,0,0,1,6,  3,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  4,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if (got0 !== e) begin
        bad++;
        $display("FAIL tick_qual[%0d]: got %s want %s", i, fmt(got0), fmt(e));
      end else $display("ok   tick_qual[%0d]: %s", i, fmt(got0));
    end
  endtask

  task automatic test_hold();
    row_t rows[$];
    obs_t e;
    rnw = 1'b0; ccc = 1'b0; wr_len = 16'd4;
    rows.push_back(mk(0,0,0,0,0,  4,0,0,0,0));
    rows.push_back(mk(1,1,0,0,0,  4,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 3,0,0,0,0));
    rows.push_back(mk(1,1,0,1,16, 3,0,0,0,0));
    rows.push_back(mk(1,1,0,1,6,  3,0,0,0,0));
    rows.push_back(mk(1,1,0,0,0,  3,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 2,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 1,1,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 0,0,1,1,0));
    rows.push_back(mk(1,1,0,1,16, 0,0,1,0,0));
    rows.push_back(mk(1,0,0,1,16, 0,0,1,0,1));
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  9,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      // Length change mid-transfer must only take effect after IDLE.
      if (i == 3) wr_len = 16'd9;
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if (got0 !== e) begin
        bad++;
        $display("FAIL hold[%0d]: got %s want %s", i, fmt(got0), fmt(e));
      end else $display("ok   hold[%0d]: %s", i, fmt(got0));
    end
  endtask

  task automatic test_abort();
    row_t rows[$];
    obs_t e;
    rnw = 1'b0; ccc = 1'b0; wr_len = 16'd2;
    rows.push_back(mk(0,0,0,0,0,  2,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,  2,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 1,1,0,0,0));
    rows.push_back(mk(1,0,1,1,16, 0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  2,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,  2,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 1,1,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 0,0,1,1,0));
    rows.push_back(mk(1,0,1,1,16, 0,0,0,0,0));
    rows.push_back(mk(1,0,1,0,0,  0,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,  2,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,  2,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if (got0 !== e) begin
        bad++;
        $display("FAIL abort[%0d]: got %s want %s", i, fmt(got0), fmt(e));
      end else $display("ok   abort[%0d]: %s", i, fmt(got0));
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    obs_t e;
    rnw = 1'b0; ccc = 1'b0; wr_len = 16'd2;
    rows.push_back(mk(0,0,0,0,0,  2,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,  2,0,0,0,0));
    rows.push_back(mk(1,0,0,1,16, 1,1,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if (got0 !== e) begin
        bad++;
        $display("FAIL reset_mid[%0d]: got %s want %s", i, fmt(got0), fmt(e));
      end else $display("ok   reset_mid[%0d]: %s", i, fmt(got0));
    end
    // Reset asserted between clock edges: outputs must clear without a clock.
    tog = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    total++;
    if (got0 !== e) begin
      bad++;
      $display("FAIL reset_async: got %s want %s", fmt(got0), fmt(e));
    end else $display("ok   reset_async: %s", fmt(got0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rows.delete();
    rows.push_back(mk(0,0,0,0,0,  2,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if (got0 !== e) begin
        bad++;
        $display("FAIL reset_after[%0d]: got %s want %s", i, fmt(got0), fmt(e));
      end else $display("ok   reset_after[%0d]: %s", i, fmt(got0));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write();
    test_ccc_zero();
    test_byte_mode();
    test_tick_qual();
    test_hold();
    test_abort();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
